// File: rtl/ppa_sub_pkg.sv
// ppa_sub_pkg: shared FSM state type and sizing helpers for the digit-serial subtractor
package ppa_sub_pkg;
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;
  function automatic int num_digits(input int width, input int digit);
    return width / digit;
  endfunction
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/ppa_sub_digit.sv
// ppa_sub_digit: combinational DIGIT-bit subtract slice, generate/propagate on a and ~b with rippled borrow
module ppa_sub_digit #(
  parameter int DIGIT = 4
) (
  input  logic [DIGIT-1:0] a_d,
  input  logic [DIGIT-1:0] b_d,
  input  logic             bin_d,
  output logic [DIGIT-1:0] diff_d,
  output logic             bout_d
);
  logic [DIGIT-1:0] g;
  logic [DIGIT-1:0] p;
  logic [DIGIT:0]   c;
  assign g = a_d & ~b_d;
  assign p = a_d ^ ~b_d;
  // grey-cell carry ripple; carry-in is the complement of the incoming borrow
  always_comb begin
    c = '0;
    c[0] = ~bin_d;
    for (int i = 0; i < DIGIT; i++) c[i+1] = g[i] | (p[i] & c[i]);
  end
  assign diff_d = p ^ c[DIGIT-1:0];
  assign bout_d = ~c[DIGIT];
endmodule

// File: rtl/ppa_serial_sub.sv
// ppa_serial_sub: digit-serial a - b - bin, LSD first, valid/ready handshakes; PPA_SUB_OVF_EN adds signed-overflow output ovf
module ppa_serial_sub
  import ppa_sub_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
`ifdef PPA_SUB_OVF_EN
  output logic             ovf,
`endif
  output logic             bout
);
  localparam int ND = num_digits(WIDTH, DIGIT);
  localparam int CW = cnt_width(ND);
  localparam logic [CW-1:0] LAST = CW'(ND - 1);
  if (WIDTH % DIGIT != 0) begin : g_bad_digit
    $error("ppa_serial_sub: WIDTH must be a multiple of DIGIT");
  end
  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, diff_q, diff_d;
  logic             brw_q, brw_d, bout_q, bout_d;
  logic [DIGIT-1:0] dig_diff;
  logic             dig_bout;
`ifdef PPA_SUB_OVF_EN
  logic             ovf_q, ovf_d;
  assign ovf = ovf_q;
`endif
  ppa_sub_digit #(.DIGIT(DIGIT)) u_digit (
    .a_d   (a_q[cnt_q*DIGIT +: DIGIT]),
    .b_d   (b_q[cnt_q*DIGIT +: DIGIT]),
    .bin_d (brw_q),
    .diff_d(dig_diff),
    .bout_d(dig_bout)
  );
  assign in_ready  = state_q == IDLE;
  assign out_valid = state_q == DONE;
  assign diff      = diff_q;
  assign bout      = bout_q;
  // next-state: capture on acceptance, one digit per BUSY cycle, hold result until consumed
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    brw_d   = brw_q;
    diff_d  = diff_q;
    bout_d  = bout_q;
`ifdef PPA_SUB_OVF_EN
    ovf_d   = ovf_q;
`endif
    case (state_q)
      IDLE: if (in_valid) begin
        a_d     = a;
        b_d     = b;
        brw_d   = bin;
        cnt_d   = '0;
        diff_d  = '0;
        state_d = BUSY;
      end
      BUSY: begin
        diff_d[cnt_q*DIGIT +: DIGIT] = dig_diff;
        brw_d = dig_bout;
        if (cnt_q == LAST) begin
          bout_d  = dig_bout;
`ifdef PPA_SUB_OVF_EN
          ovf_d   = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (dig_diff[DIGIT-1] != a_q[WIDTH-1]);
`endif
          state_d = DONE;
        end else cnt_d = cnt_q + 1'b1;
      end
      DONE: state_d = out_ready ? IDLE : DONE;
      default: state_d = IDLE;
    endcase
  end
  // state and datapath registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      brw_q   <= 1'b0;
      diff_q  <= '0;
      bout_q  <= 1'b0;
`ifdef PPA_SUB_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      brw_q   <= brw_d;
      diff_q  <= diff_d;
      bout_q  <= bout_d;
`ifdef PPA_SUB_OVF_EN
      ovf_q   <= ovf_d;
`endif
    end
  end
endmodule

// File: tb/tb_ppa_serial_sub.sv
// tb_ppa_serial_sub: three DUTs (DIGIT 1/4/16) driven in lockstep, checked against an integer-arithmetic model
module tb_ppa_serial_sub;
  localparam int W = 16;
  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          out_ready = 1'b1;
  logic          bin = 1'b0;
  logic [W-1:0]  a = '0;
  logic [W-1:0]  b = '0;
  logic          ir [3];
  logic          ov [3];
  logic          bo [3];
  logic [W-1:0]  df [3];
`ifdef PPA_SUB_OVF_EN
  logic          of [3];
`endif
  int errors = 0;
  int checks = 0;
  always #5 clk = ~clk;
  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int DG = (g == 0) ? 1 : ((g == 1) ? 4 : 16);
    ppa_serial_sub #(.WIDTH(W), .DIGIT(DG)) u_dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .in_valid (in_valid),
      .in_ready (ir[g]),
      .a        (a),
      .b        (b),
      .bin      (bin),
      .out_valid(ov[g]),
      .out_ready(out_ready),
      .diff     (df[g]),
`ifdef PPA_SUB_OVF_EN
      .ovf      (of[g]),
`endif
      .bout     (bo[g])
    );
  end
  function automatic int nd(input int i);
    return (i == 0) ? 16 : ((i == 1) ? 4 : 1);
  endfunction
  function automatic logic [17:0] model(input logic [15:0] x, input logic [15:0] y, input logic z);
    int r;
    logic [15:0] d;
    r = int'(x) - int'(y) - int'(z);
    d = r[15:0];
    return {(x[15] != y[15]) && (d[15] != x[15]), r < 0, d};
  endfunction
  task automatic chk(input string tag, input int i, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s dut%0d: observed %h expected %h", tag, i, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic start(input logic [15:0] ta, input logic [15:0] tb_v, input logic tbi);
    for (int i = 0; i < 3; i++) chk("in_ready before op", i, ir[i], 1);
    a = ta;
    b = tb_v;
    bin = tbi;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask
  task automatic run_op(input logic [15:0] ta, input logic [15:0] tb_v, input logic tbi);
    logic [17:0] m;
    int lat [3];
    int cnt [3];
    logic [15:0] got [3];
    logic gb [3];
`ifdef PPA_SUB_OVF_EN
    logic go [3];
`endif
    m = model(ta, tb_v, tbi);
    out_ready = 1'b1;
    start(ta, tb_v, tbi);
    a = 16'($urandom);
    b = 16'($urandom);
    for (int i = 0; i < 3; i++) begin
      lat[i] = 0;
      cnt[i] = 0;
      got[i] = '0;
      gb[i] = 1'b0;
`ifdef PPA_SUB_OVF_EN
      go[i] = 1'b0;
`endif
    end
    for (int c = 1; c <= 18; c++) begin
      tick();
      for (int i = 0; i < 3; i++) if (ov[i]) begin
        if (cnt[i] == 0) lat[i] = c;
        cnt[i]++;
        got[i] = df[i];
        gb[i] = bo[i];
`ifdef PPA_SUB_OVF_EN
        go[i] = of[i];
`endif
      end
    end
    for (int i = 0; i < 3; i++) begin
      chk("latency", i, lat[i], nd(i));
      chk("deliveries", i, cnt[i], 1);
      chk("diff", i, got[i], m[15:0]);
      chk("bout", i, gb[i], m[16]);
`ifdef PPA_SUB_OVF_EN
      chk("ovf", i, go[i], m[17]);
`endif
    end
  endtask
  initial begin
    logic [17:0] m;
    int seen;
    #12;
    for (int i = 0; i < 3; i++) begin
      chk("reset in_ready", i, ir[i], 1);
      chk("reset out_valid", i, ov[i], 0);
      chk("reset diff", i, df[i], 0);
      chk("reset bout", i, bo[i], 0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    run_op(16'h1234, 16'h0234, 1'b0);
    run_op(16'h0000, 16'h0001, 1'b0);
    run_op(16'h8000, 16'h0001, 1'b0);
    run_op(16'h5555, 16'h5555, 1'b1);
    run_op(16'hFFFF, 16'hFFFF, 1'b1);
    run_op(16'h0000, 16'h0000, 1'b0);
    run_op(16'h7FFF, 16'h8000, 1'b0);
    m = model(16'h9ABC, 16'h1234, 1'b1);
    out_ready = 1'b0;
    start(16'h9ABC, 16'h1234, 1'b1);
    in_valid = 1'b1;
    repeat (20) begin
      a = 16'($urandom);
      b = 16'($urandom);
      bin = 1'($urandom);
      tick();
    end
    for (int k = 0; k < 10; k++) begin
      a = 16'($urandom);
      b = 16'($urandom);
      tick();
      for (int i = 0; i < 3; i++) begin
        chk("held out_valid", i, ov[i], 1);
        chk("held in_ready", i, ir[i], 0);
        chk("held diff", i, df[i], m[15:0]);
        chk("held bout", i, bo[i], m[16]);
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    for (int i = 0; i < 3; i++) begin
      chk("release out_valid", i, ov[i], 0);
      chk("release in_ready", i, ir[i], 1);
    end
    out_ready = 1'b0;
    start(16'hFFFF, 16'h0001, 1'b0);
    tick();
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      chk("async rst out_valid", i, ov[i], 0);
      chk("async rst diff", i, df[i], 0);
      chk("async rst in_ready", i, ir[i], 1);
      chk("async rst bout", i, bo[i], 0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (20) begin
      tick();
      for (int i = 0; i < 3; i++) if (ov[i]) seen++;
    end
    chk("no pulse after reset", 0, seen, 0);
    run_op(16'hFFFF, 16'h0001, 1'b0);
    for (int n = 0; n < 1500; n++) run_op(16'($urandom), 16'($urandom), 1'($urandom));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
